// File: rtl/bakraid_snd_pkg.sv
// Shared constants and types for the Bakraid sound-ROM fetch path.
// Bank layout of the YMZ280B sample space across the three PCM SDRAM slots.
package bakraid_snd_pkg;

  localparam logic [23:0] PCM_BASE  = 24'h000000;
  localparam logic [23:0] PCM1_BASE = 24'h400000;
  localparam logic [23:0] PCM2_BASE = 24'h800000;
  localparam logic [23:0] OOR_BASE  = 24'hC00000;

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, RESP} state_e;

  typedef logic [1:0] bank_t;

  function automatic bank_t bank_of(input logic [23:0] a);
    return a[23:22];
  endfunction

  function automatic logic is_oor(input logic [23:0] a);
    return a >= OOR_BASE;
  endfunction

  function automatic logic [23:0] bank_base(input bank_t b);
    logic [23:0] r;
    case (b)
      2'd0:    r = PCM_BASE;
      2'd1:    r = PCM1_BASE;
      2'd2:    r = PCM2_BASE;
      default: r = OOR_BASE;
    endcase
    return r;
  endfunction

  function automatic logic [21:0] slot_addr(input logic [23:0] a);
    logic [23:0] rel;
    rel = a - bank_base(bank_of(a));
    return rel[21:0];
  endfunction

endpackage

// File: rtl/bakraid_pcm_linebuf.sv
// One-line read buffer: byte storage, tag/valid compare and flush tracking.
// A flush seen at any point during a fill keeps the completed line invalid.
module bakraid_pcm_linebuf #(
  parameter int unsigned LINE_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                fill_start,
  input  logic                fill_done,
  input  logic [23-LINE_W:0]  fill_tag,
  input  logic [23-LINE_W:0]  lookup_tag,
  input  logic                wr_en,
  input  logic [LINE_W-1:0]   wr_idx,
  input  logic [7:0]          wr_data,
  input  logic [LINE_W-1:0]   rd_idx,
  output logic [7:0]          rd_data,
  output logic [23-LINE_W:0]  line_tag,
  output logic                hit
);

  localparam int unsigned DEPTH = 1 << LINE_W;

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [23-LINE_W:0]    tag_q, tag_d;
  logic                  valid_q, valid_d;
  logic                  flushed_q, flushed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      flushed_q <= flushed_d;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    flushed_d = flushed_q | flush;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
    if (fill_start) begin
      tag_d     = fill_tag;
      flushed_d = 1'b0;
    end
    if (fill_start || flush) begin
      valid_d = 1'b0;
    end else if (fill_done && !flushed_q) begin
      valid_d = 1'b1;
    end
  end

  assign rd_data  = mem_q[rd_idx];
  assign line_tag = tag_q;
  assign hit      = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/bakraid_pcm_fetch.sv
// YMZ280B sample-ROM read port bridged onto the PCM/PCM1/PCM2 SDRAM slots
// through a one-line buffer; addresses at or above the last bank read 0x00.
module bakraid_pcm_fetch #(
  parameter int unsigned LINE_W    = 2,
  parameter int unsigned OK_SETTLE = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FLUSH,
  input  logic        YMZ_RD,
  input  logic [23:0] YMZ_ADDR,
  output logic [7:0]  YMZ_DOUT,
  output logic        YMZ_VALID,
  output logic        PCM_CS,
  output logic        PCM1_CS,
  output logic        PCM2_CS,
  output logic [21:0] PCM_ADDR,
  output logic [21:0] PCM1_ADDR,
  output logic [21:0] PCM2_ADDR,
  input  logic        PCM_OK,
  input  logic        PCM1_OK,
  input  logic        PCM2_OK,
  input  logic [7:0]  PCM_DOUT,
  input  logic [7:0]  PCM1_DOUT,
  input  logic [7:0]  PCM2_DOUT
);

  import bakraid_snd_pkg::*;

  localparam int unsigned TAG_W = 24 - LINE_W;
  localparam int unsigned CNT_W = (OK_SETTLE > 1) ? $clog2(OK_SETTLE) : 1;

  state_e                state_q, state_d;
  logic [LINE_W-1:0]     k_q, k_d, off_q, off_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  oor_q, oor_d;
  logic [2:0]            cs_q, cs_d;
  logic [2:0][21:0]      addr_q, addr_d;
  logic [7:0]            dout_q, dout_d;
  logic                  valid_q, valid_d;

  logic [TAG_W-1:0]      line_tag;
  logic [7:0]            buf_rd;
  logic                  hit;
  logic                  req, req_oor, req_hit;
  bank_t                 req_bank, line_bank;
  logic [21:0]           req_line;
  logic                  settle_done, last_byte;
  logic                  sel_ok;
  logic [7:0]            sel_dout;
  logic                  fill_start, fill_done, wr_en;
  logic [LINE_W-1:0]     k_nxt;

  // RD is ignored while the VALID strobe is out, so a still-high RD is not re-taken
  assign req         = (state_q == IDLE) && YMZ_RD && !valid_q;
  assign req_oor     = is_oor(YMZ_ADDR);
  assign req_bank    = bank_of(YMZ_ADDR);
  assign req_hit     = hit && !FLUSH;
  assign req_line    = (slot_addr(YMZ_ADDR) >> LINE_W) << LINE_W;
  assign line_bank   = bank_t'(line_tag[TAG_W-1 -: 2]);
  assign settle_done = (cnt_q == CNT_W'(OK_SETTLE - 1));
  assign last_byte   = &k_q;
  assign k_nxt       = k_q + LINE_W'(1);

  always_comb begin
    sel_ok   = 1'b0;
    sel_dout = '0;
    case (line_bank)
      2'd0:    begin sel_ok = PCM_OK;  sel_dout = PCM_DOUT;  end
      2'd1:    begin sel_ok = PCM1_OK; sel_dout = PCM1_DOUT; end
      2'd2:    begin sel_ok = PCM2_OK; sel_dout = PCM2_DOUT; end
      default: begin sel_ok = 1'b0;    sel_dout = '0;        end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      k_q     <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      oor_q   <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      oor_q   <= oor_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (req_oor || req_hit) ? RESP : SETTLE;
      SETTLE:  if (settle_done) state_d = WAIT;
      WAIT:    if (sel_ok) state_d = last_byte ? RESP : SETTLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_start = req && !req_oor && !req_hit;
    wr_en      = (state_q == WAIT) && sel_ok;
    fill_done  = wr_en && last_byte;
  end

  always_comb begin
    k_d     = k_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    oor_d   = oor_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          off_d = YMZ_ADDR[LINE_W-1:0];
          oor_d = req_oor;
        end
        if (fill_start) begin
          k_d   = '0;
          cnt_d = '0;
          cs_d  = 3'b001 << req_bank;
          for (int unsigned b = 0; b < 3; b++) begin
            if (req_bank == bank_t'(b)) addr_d[b] = req_line;
          end
        end
      end
      SETTLE: begin
        if (!settle_done) cnt_d = cnt_q + CNT_W'(1);
      end
      WAIT: begin
        if (sel_ok) begin
          if (last_byte) begin
            cs_d = '0;
          end else begin
            k_d   = k_nxt;
            cnt_d = '0;
            for (int unsigned b = 0; b < 3; b++) begin
              if (line_bank == bank_t'(b)) addr_d[b] = {line_tag[21-LINE_W:0], k_nxt};
            end
          end
        end
      end
      RESP: begin
        cs_d    = '0;
        valid_d = 1'b1;
        dout_d  = oor_q ? 8'h00 : buf_rd;
      end
      default: ;
    endcase
  end

  bakraid_pcm_linebuf #(.LINE_W(LINE_W)) u_linebuf (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .flush      (FLUSH),
    .fill_start (fill_start),
    .fill_done  (fill_done),
    .fill_tag   (YMZ_ADDR[23:LINE_W]),
    .lookup_tag (YMZ_ADDR[23:LINE_W]),
    .wr_en      (wr_en),
    .wr_idx     (k_q),
    .wr_data    (sel_dout),
    .rd_idx     (off_q),
    .rd_data    (buf_rd),
    .line_tag   (line_tag),
    .hit        (hit)
  );

  assign YMZ_DOUT  = dout_q;
  assign YMZ_VALID = valid_q;
  assign PCM_CS    = cs_q[0];
  assign PCM1_CS   = cs_q[1];
  assign PCM2_CS   = cs_q[2];
  assign PCM_ADDR  = addr_q[0];
  assign PCM1_ADDR = addr_q[1];
  assign PCM2_ADDR = addr_q[2];

endmodule

// File: tb/tb_bakraid_pcm_fetch.sv
// Directed bench for bakraid_pcm_fetch with a three-slot SDRAM model whose OK
// and data lag the address, so a stale OK after an address change reads wrong data.
module tb_bakraid_pcm_fetch;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        YMZ_RD = 1'b0;
  logic [23:0] YMZ_ADDR = '0;
  logic [7:0]  YMZ_DOUT;
  logic        YMZ_VALID;
  logic        PCM_CS, PCM1_CS, PCM2_CS;
  logic [21:0] PCM_ADDR, PCM1_ADDR, PCM2_ADDR;
  logic        PCM_OK, PCM1_OK, PCM2_OK;
  logic [7:0]  PCM_DOUT, PCM1_DOUT, PCM2_DOUT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  bakraid_pcm_fetch #(.LINE_W(2), .OK_SETTLE(1)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .FLUSH     (FLUSH),
    .YMZ_RD    (YMZ_RD),
    .YMZ_ADDR  (YMZ_ADDR),
    .YMZ_DOUT  (YMZ_DOUT),
    .YMZ_VALID (YMZ_VALID),
    .PCM_CS    (PCM_CS),
    .PCM1_CS   (PCM1_CS),
    .PCM2_CS   (PCM2_CS),
    .PCM_ADDR  (PCM_ADDR),
    .PCM1_ADDR (PCM1_ADDR),
    .PCM2_ADDR (PCM2_ADDR),
    .PCM_OK    (PCM_OK),
    .PCM1_OK   (PCM1_OK),
    .PCM2_OK   (PCM2_OK),
    .PCM_DOUT  (PCM_DOUT),
    .PCM1_DOUT (PCM1_DOUT),
    .PCM2_DOUT (PCM2_DOUT)
  );

  function automatic logic [7:0] mem_byte(input int b, input logic [21:0] a);
    logic [1:0] bb;
    bb = 2'(b);
    return a[7:0] ^ a[15:8] ^ {bb, bb, bb, bb};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [23:0] a);
    return (a >= 24'hC00000) ? 8'h00 : mem_byte(int'(a[23:22]), a[21:0]);
  endfunction

  // SDRAM slot model: OK rises three cycles after CS/ADDR settle
  logic [2:0]  m_cs;
  logic [21:0] m_addr [3];
  logic [21:0] m_prev [3];
  int          m_age  [3];
  logic [2:0]  m_ok;
  logic [7:0]  m_dout [3];

  assign m_cs      = {PCM2_CS, PCM1_CS, PCM_CS};
  assign m_addr[0] = PCM_ADDR;
  assign m_addr[1] = PCM1_ADDR;
  assign m_addr[2] = PCM2_ADDR;
  assign PCM_OK    = m_ok[0];
  assign PCM1_OK   = m_ok[1];
  assign PCM2_OK   = m_ok[2];
  assign PCM_DOUT  = m_dout[0];
  assign PCM1_DOUT = m_dout[1];
  assign PCM2_DOUT = m_dout[2];

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int b = 0; b < 3; b++) begin
        m_prev[b] <= '0;
        m_age[b]  <= 0;
        m_ok[b]   <= 1'b0;
        m_dout[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (m_cs[b] && m_addr[b] == m_prev[b])
          m_age[b] <= (m_age[b] < 8) ? m_age[b] + 1 : m_age[b];
        else
          m_age[b] <= 0;
        m_prev[b] <= m_addr[b];
        m_ok[b]   <= m_cs[b] && (m_addr[b] == m_prev[b]) && (m_age[b] >= 1);
        m_dout[b] <= mem_byte(b, m_prev[b]);
      end
    end
  end

  logic [23:0] fetch_q[$];
  logic [2:0]  mon_cs = '0;
  logic [21:0] mon_addr [3];
  int          cs_viol = 0;
  int          vld_cnt = 0;

  always @(negedge CLK) begin
    for (int b = 0; b < 3; b++) begin
      if (m_cs[b] && (!mon_cs[b] || m_addr[b] != mon_addr[b]))
        fetch_q.push_back({2'(b), m_addr[b]});
      mon_addr[b] <= m_addr[b];
    end
    mon_cs <= m_cs;
    if (!$onehot0(m_cs)) cs_viol <= cs_viol + 1;
    if (YMZ_VALID) vld_cnt <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after a negedge; returns the byte and the negedges until VALID.
  task automatic ymz_read(input logic [23:0] a, output logic [7:0] d, output int lat);
    YMZ_ADDR = a;
    YMZ_RD   = 1'b1;
    lat      = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!YMZ_VALID && lat < 400);
    check("valid_seen", 32'(YMZ_VALID), 32'd1);
    d      = YMZ_DOUT;
    YMZ_RD = 1'b0;
    @(negedge CLK);
    check("valid_pulse_1cyc", 32'(YMZ_VALID), 32'd0);
  endtask

  task automatic check_fetch(input string tag, input int bank, input logic [21:0] base);
    #1;
    check({tag, "_nfetch"}, 32'(fetch_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < fetch_q.size())
        check({tag, "_fetch_addr"}, 32'(fetch_q[i]), 32'({2'(bank), base + 22'(i)}));
    end
  endtask

  task automatic hit_read(input logic [23:0] a);
    logic [7:0] d;
    int lat;
    fetch_q.delete();
    ymz_read(a, d, lat);
    check("hit_data", 32'(d), 32'(exp_byte(a)));
    check("hit_latency", 32'(lat), 32'd2);
    #1;
    check("hit_no_cs", 32'(fetch_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int lat, w, vld_before;

    repeat (3) @(negedge CLK);
    check("rst_cs", 32'(m_cs), 32'd0);
    check("rst_pcm_addr", 32'(PCM_ADDR), 32'd0);
    check("rst_pcm1_addr", 32'(PCM1_ADDR), 32'd0);
    check("rst_pcm2_addr", 32'(PCM2_ADDR), 32'd0);
    check("rst_dout", 32'(YMZ_DOUT), 32'd0);
    check("rst_valid", 32'(YMZ_VALID), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Cold miss in bank 0
    fetch_q.delete();
    ymz_read(24'h000005, d, lat);
    check("miss0_data", 32'(d), 32'(exp_byte(24'h000005)));
    check_fetch("miss0", 0, 22'h000004);

    // Sequential hits in the same line
    hit_read(24'h000006);
    hit_read(24'h000007);

    // Bank 1 and bank 2 misses
    fetch_q.delete();
    ymz_read(24'h4ABCDE, d, lat);
    check("miss1_data", 32'(d), 32'(exp_byte(24'h4ABCDE)));
    check_fetch("miss1", 1, 22'h0ABCDC);
    fetch_q.delete();
    ymz_read(24'h8ABCDE, d, lat);
    check("miss2_data", 32'(d), 32'(exp_byte(24'h8ABCDE)));
    check_fetch("miss2", 2, 22'h0ABCDC);

    // Out-of-range reads return zero and leave the line alone
    hit_read(24'hC00010);
    hit_read(24'hFFFFFF);
    hit_read(24'h8ABCDD);

    // Flush during a fill: response still correct, line left invalid
    fetch_q.delete();
    fork
      ymz_read(24'h000005, d, lat);
      begin
        repeat (6) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
      end
    join
    check("flush_data", 32'(d), 32'(exp_byte(24'h000005)));
    check_fetch("flush", 0, 22'h000004);
    fetch_q.delete();
    ymz_read(24'h000006, d, lat);
    check("refetch_data", 32'(d), 32'(exp_byte(24'h000006)));
    check_fetch("refetch", 0, 22'h000004);

    // Reset in the middle of a fill
    YMZ_ADDR = 24'h400010;
    YMZ_RD   = 1'b1;
    w = 0;
    while (!PCM1_CS && w < 50) begin
      @(negedge CLK);
      w++;
    end
    check("rstfill_cs_rise", 32'(PCM1_CS), 32'd1);
    @(negedge CLK);
    #1;
    vld_before = vld_cnt;
    RESET_N = 1'b0;
    #1;
    check("rstfill_cs_drop", 32'(m_cs), 32'd0);
    check("rstfill_addr", 32'(PCM1_ADDR), 32'd0);
    check("rstfill_dout", 32'(YMZ_DOUT), 32'd0);
    repeat (3) @(negedge CLK);
    YMZ_RD = 1'b0;
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rstfill_no_valid", 32'(vld_cnt), 32'(vld_before));
    @(negedge CLK);
    fetch_q.delete();
    ymz_read(24'h400010, d, lat);
    check("postrst_data", 32'(d), 32'(exp_byte(24'h400010)));
    check_fetch("postrst", 1, 22'h000010);

    #1;
    check("cs_onehot", 32'(cs_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
